// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types: the M-extension op selector and the muldiv_unit sequencer states.
package rv32i_types;

    typedef enum logic [1:0] {
        m_mul = 2'b00,
        m_div = 2'b01,
        m_rem = 2'b10
    } m_ops;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } muldiv_state_t;

    localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor when it fits.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, dividend_bit_i};
        diff    = shifted - {1'b0, divisor_i};
        // A clear borrow bit means the divisor fit into the shifted remainder.
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension multiply/divide sequencer; MULDIV_EARLY_OUT_EN lets trivial cases skip CALC.
// state | meaning
// IDLE  | waiting for start; latches operand magnitudes, signs and special-case flags
// CALC  | one shift-add (mul) or restoring step (div/rem) per cycle, WIDTH cycles
// FIXUP | sign correction / special-case override, result registered
// DONE  | done pulse for one cycle
module muldiv_unit
    import rv32i_types::*;
#(
    parameter int WIDTH = MULDIV_ITERS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               kill,
    input  m_ops               mulop,
    input  logic               rs1_signed,
    input  logic               rs2_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] mext_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    muldiv_state_t      state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div_zero_q, div_zero_d;
    logic               div_ovf_q, div_ovf_d;
    logic               mul_zero_q, mul_zero_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               sign_a_in, sign_b_in, is_div_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero_in, div_ovf_in, mul_zero_in, skip_calc;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix, fix_result;

    assign sign_a_in   = rs1_signed & a[WIDTH-1];
    assign sign_b_in   = rs2_signed & b[WIDTH-1];
    assign a_mag       = sign_a_in ? -a : a;
    assign b_mag       = sign_b_in ? -b : b;
    assign is_div_in   = (mulop != m_mul);
    assign div_zero_in = is_div_in && (b == '0);
    assign div_ovf_in  = is_div_in && rs1_signed && rs2_signed &&
                         (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign mul_zero_in = !is_div_in && ((a == '0) || (b == '0));

`ifdef MULDIV_EARLY_OUT_EN
    assign skip_calc = div_zero_in || div_ovf_in || mul_zero_in;
`else
    assign skip_calc = 1'b0;
`endif

    // work_q holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div.
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i          (work_q[2*WIDTH-1:WIDTH]),
        .dividend_bit_i (work_q[WIDTH-1]),
        .divisor_i      (opnd_q),
        .rem_o          (div_rem),
        .q_bit_o        (div_qbit)
    );

    assign div_next = {div_rem, work_q[WIDTH-2:0], div_qbit};

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
        if (div_zero_q)
            fix_result = {a_q, {WIDTH{1'b1}}};
        else if (div_ovf_q)
            fix_result = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
        else if (mul_zero_q)
            fix_result = '0;
        else if (is_div_q)
            fix_result = {rem_fix, quo_fix};
        else
            fix_result = prod_fix;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        work_d     = work_q;
        opnd_d     = opnd_q;
        a_d        = a_q;
        is_div_d   = is_div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        div_ovf_d  = div_ovf_q;
        mul_zero_d = mul_zero_q;
        result_d   = result_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        count_d    = '0;
                        work_d     = {{WIDTH{1'b0}}, (is_div_in ? a_mag : b_mag)};
                        opnd_d     = is_div_in ? b_mag : a_mag;
                        a_d        = a;
                        is_div_d   = is_div_in;
                        sign_a_d   = sign_a_in;
                        sign_b_d   = sign_b_in;
                        div_zero_d = div_zero_in;
                        div_ovf_d  = div_ovf_in;
                        mul_zero_d = mul_zero_in;
                        state_d    = skip_calc ? FIXUP : CALC;
                    end
                end
                CALC: begin
                    work_d  = is_div_q ? div_next : mul_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_STEP)
                        state_d = FIXUP;
                end
                FIXUP: begin
                    result_d = fix_result;
                    state_d  = DONE;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            work_q     <= '0;
            opnd_q     <= '0;
            a_q        <= '0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            mul_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            work_q     <= work_d;
            opnd_q     <= opnd_d;
            a_q        <= a_d;
            is_div_q   <= is_div_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            div_ovf_q  <= div_ovf_d;
            mul_zero_q <= mul_zero_d;
            result_q   <= result_d;
        end
    end

    assign busy     = (state_q == CALC) || (state_q == FIXUP);
    assign done     = (state_q == DONE);
    assign mext_out = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;
    import rv32i_types::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, kill, rs1_signed, rs2_signed;
    m_ops         mulop;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [2*W-1:0] mext_out;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kill       (kill),
        .mulop      (mulop),
        .rs1_signed (rs1_signed),
        .rs2_signed (rs2_signed),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .mext_out   (mext_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    logic [63:0] last_res = '0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input m_ops op, input bit s1, input bit s2,
                                          input logic [31:0] ia, input logic [31:0] ib);
        longint ax, bx, q, r;
        logic [63:0] p;
        ax = s1 ? longint'($signed(ia)) : longint'({32'b0, ia});
        bx = s2 ? longint'($signed(ib)) : longint'({32'b0, ib});
        if (op == m_mul) begin
            p = ax * bx;
            return p;
        end
        if (ib == 32'd0) return {ia, 32'hFFFF_FFFF};
        q = ax / bx;
        r = ax % bx;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int lat_of(input m_ops op, input bit s1, input bit s2,
                                  input logic [31:0] ia, input logic [31:0] ib);
`ifdef MULDIV_EARLY_OUT_EN
        if (op == m_mul && (ia == 0 || ib == 0)) return 1;
        if (op != m_mul && ib == 0) return 1;
        if (op != m_mul && s1 && s2 && ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check64("result", mext_out, mon_e.res);
                check64("latency_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic issue(input m_ops op, input bit s1, input bit s2, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [63:0] exp, input bit push);
        exp_t e;
        @(posedge clk); #1;
        mulop = op; rs1_signed = s1; rs2_signed = s2; a = ia; b = ib; start = 1'b1;
        if (push) begin
            e.res = exp;
            e.due = cyc + 1 + lat_of(op, s1, s2, ia, ib);
            sb.push_back(e);
            last_res = exp;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check64("busy_after_start", {63'b0, busy}, 64'd1);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within 60 cycles, required one");
            sb.delete();
        end else begin
            check64("busy_in_done", {63'b0, busy}, 64'd0);
        end
    endtask

    task automatic run_op(input m_ops op, input bit s1, input bit s2, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [63:0] exp);
        issue(op, s1, s2, ia, ib, exp, 1'b1);
        wait_done();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; kill = 1'b0; mulop = m_mul;
        rs1_signed = 1'b0; rs2_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_busy", {63'b0, busy}, 64'd0);
        check64("reset_done", {63'b0, done}, 64'd0);
        check64("reset_mext", mext_out, 64'd0);
        rst = 1'b0;

        run_op(m_mul, 1, 1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(m_mul, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op(m_mul, 1, 0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(m_div, 1, 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(m_rem, 1, 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(m_div, 0, 0, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
        run_op(m_rem, 1, 1, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
        run_op(m_div, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op(m_mul, 1, 0, 32'd0, 32'd12345, 64'h0);

        // kill beats start in the same cycle
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; mulop = m_mul; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check64("kill_vs_start_busy", {63'b0, busy}, 64'd0);

        // kill ten cycles into CALC: no done, old result kept
        dn = n_done;
        issue(m_mul, 1, 1, 32'd123, 32'd456, 64'h0, 1'b0);
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check64("kill_busy", {63'b0, busy}, 64'd0);
        check64("kill_mext_kept", mext_out, last_res);
        repeat (40) @(posedge clk);
        check64("kill_no_done", 64'(n_done), 64'(dn));

        // start held for the whole operation yields exactly one done
        dn = n_done;
        begin
            exp_t e;
            bit got = 1'b0;
            @(posedge clk); #1;
            mulop = m_mul; rs1_signed = 0; rs2_signed = 0;
            a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
            e.res = 64'hFFFF_FFFE_0000_0001;
            e.due = cyc + 1 + 33;
            sb.push_back(e);
            last_res = e.res;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            start = 1'b0;
        end
        repeat (40) @(posedge clk);
        check64("held_start_one_done", 64'(n_done), 64'(dn + 1));

        // asynchronous reset in the middle of CALC
        issue(m_div, 0, 0, 32'd100, 32'd7, model(m_div, 0, 0, 32'd100, 32'd7), 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check64("arst_busy", {63'b0, busy}, 64'd0);
        check64("arst_done", {63'b0, done}, 64'd0);
        check64("arst_mext", mext_out, 64'd0);
        sb.delete();
        last_res = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run_op(m_div, 0, 0, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

        for (int i = 0; i < 40; i++) begin
            m_ops        op;
            bit          s1, s2;
            logic [31:0] ra, rb;
            op = m_ops'($urandom_range(0, 2));
            s1 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            ra = pick_operand();
            rb = pick_operand();
            run_op(op, s1, s2, ra, rb, model(op, s1, s2, ra, rb));
        end

        repeat (5) @(posedge clk);
        check64("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
